ahb_lite_master: RTL
====================

Name: ahb_lite_master

Overview:
- Single-master AHB-Lite initiator. It converts a simple valid/ready command port into AHB-Lite SINGLE transfers and returns one response per command.
- It drives the system bus toward slaves such as the boot ROM and SRAM.
- It is used by test/boot sequencers and small DMA-style engines that need bus access without a CPU.

Parameters:
- HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, non-bufferable, privileged data).
- ADDR_ALIGN, 1, 1 = force HADDR low bits to zero per HSIZE; 0 = pass cmd_addr unchanged.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_size  in  2  0 = byte, 1 = halfword, 2 = word (3 treated as word).
- cmd_wdata  in  32  write data; caller places bytes on the correct lanes.
- rsp_valid  out  1  one-cycle pulse, transfer completed.
- rsp_rdata  out  32  HRDATA captured on completion (reads only; 0 for writes).
- rsp_err  out  1  transfer ended with ERROR response.
- HADDR  out  32
- HBURST  out  3  constant 3'b000 (SINGLE).
- HMASTLOCK  out  1  constant 0.
- HPROT  out  4  HPROT_VAL.
- HSIZE  out  3  {1'b0, cmd_size clipped to 2}.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HWDATA  out  32
- HWRITE  out  1
- HRDATA  in  32
- HREADY  in  1  bus ready (from slave mux).
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- All bus outputs registered.
- Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset mid-transfer abandons the transfer; no response is emitted.
- State machine (IDLE, ADDR, DATA, ERR2):
  - IDLE: cmd_ready=1. On accept, load HADDR/HWRITE/HSIZE and HTRANS=NONSEQ next cycle -> ADDR.
  - ADDR: address phase. When HREADY=1, latch cmd_wdata into HWDATA for the next cycle, set HTRANS=IDLE -> DATA.
  - DATA: data phase; HWDATA held stable.
    - HREADY=0 & HRESP=0: wait (unbounded).
    - HREADY=0 & HRESP=1: first error cycle -> ERR2; HTRANS forced IDLE.
    - HREADY=1 & HRESP=0: completion. rsp_valid=1 next cycle, rsp_rdata=HRDATA (reads), rsp_err=0 -> IDLE.
  - ERR2: waits for HREADY=1 (HRESP still 1). Then rsp_valid=1, rsp_err=1, rsp_rdata=0 -> IDLE.
- Latency (no wait states), accept cycle = T:
  - address phase T+1;
  - data phase T+2;
  - rsp_valid at T+3.
- Each wait state adds 1 cycle.
- Alignment with ADDR_ALIGN=1: HADDR[0]=0 for halfword; HADDR[1:0]=0 for word.
- HWDATA is driven only during the data phase of a write, 0 otherwise.
- Exactly one response per accepted command; responses are in order and never dropped.
- Simultaneous cmd_valid and completion in the non-pipelined build: cmd_ready=0 until IDLE, so the next accept occurs in the rsp_valid cycle at the earliest.

Optional Feature:
- Macro AHBM_PIPELINE_EN.
- Defined: the next command may be accepted during DATA, so its address phase overlaps the current data phase.
  - cmd_ready=1 in DATA when no command is pending.
  - Back-to-back zero-wait transfers sustain one transfer per cycle.
- Error handling when defined: on a first ERROR cycle with a pipelined address phase pending, HTRANS is changed to IDLE in the second error cycle (legal cancel). The pending command is reissued as NONSEQ after ERR2 completes, so it is not lost and ordering is preserved.
- Undefined: strictly non-overlapped, as described in Behaviour.

Test Plan:
- Reset held 3 cycles, then released -> all outputs at reset values, HTRANS=IDLE, cmd_ready=1 one cycle after release.
- Read: word read at 0x00000004, slave HREADY=1, HRDATA=0x00000009 -> HTRANS=NONSEQ at T+1, rsp_valid at T+3, rsp_rdata=0x00000009, rsp_err=0.
- Write with waits: halfword write at 0x20000003, data 0xBEEF0000, slave inserts 2 wait states -> HADDR=0x20000002, HSIZE=1, HWDATA stable 3 cycles, rsp_valid at T+5.
- Error: read at 0x30000000, slave gives HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1 -> rsp_valid, rsp_err=1, rsp_rdata=0, back to IDLE.
- Pipelined (AHBM_PIPELINE_EN): 4 back-to-back word reads 0x0, 0x4, 0x8, 0xC at zero wait -> consecutive NONSEQ on HTRANS; 4 consecutive rsp_valid with 0x20001000, 0x00000009, 0xBF404600, 0x46004600.
- Pipelined error recovery: error on the first of two queued reads -> second read reissued after ERR2, two responses in order, only the first with rsp_err=1.

Source files
------------

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer initiator driven by a valid/ready command port.
// Define AHBM_PIPELINE_EN to overlap the next address phase with the current data phase.
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VAL  = 4'b0011,
    parameter bit         ADDR_ALIGN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

`ifdef AHBM_PIPELINE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR2
    } state_t;

    state_t      state_q, state_d;

    logic        a_v_q, a_v_d;
    logic        a_hold_q, a_hold_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [1:0]  hsize_q, hsize_d;
    logic [31:0] a_wdata_q, a_wdata_d;

    logic        d_wr_q, d_wr_d;
    logic [31:0] hwdata_q, hwdata_d;

    logic        p_v_q, p_v_d;
    logic [31:0] p_addr_q, p_addr_d;
    logic        p_write_q, p_write_d;
    logic [1:0]  p_size_q, p_size_d;
    logic [31:0] p_wdata_q, p_wdata_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0]  c_size;
    logic [31:0] c_addr;

    logic        acc;
    logic        a_adv;
    logic        d_fin;
    logic        d_err;
    logic        enter_err;
    logic        can_issue;
    logic        took;

    always_comb begin
        c_size = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
        c_addr = cmd_addr;
        if (ADDR_ALIGN) begin
            if (c_size == 2'd1)
                c_addr[0] = 1'b0;
            else if (c_size == 2'd2)
                c_addr[1:0] = 2'b00;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_v_d       = a_v_q;
        a_hold_d    = a_hold_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        a_wdata_d   = a_wdata_q;
        d_wr_d      = d_wr_q;
        hwdata_d    = hwdata_q;
        p_v_d       = p_v_q;
        p_addr_d    = p_addr_q;
        p_write_d   = p_write_q;
        p_size_d    = p_size_q;
        p_wdata_d   = p_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        d_fin       = 1'b0;
        d_err       = 1'b0;
        enter_err   = 1'b0;
        took        = 1'b0;

        acc   = cmd_valid & cmd_ready_q;
        a_adv = a_v_q & HREADY & (state_q != S_ERR2);

        unique case (state_q)
            S_DATA: begin
                if (HREADY) begin
                    d_fin = 1'b1;
                    d_err = HRESP;
                end else if (HRESP) begin
                    enter_err = 1'b1;
                end
            end
            S_ERR2: begin
                if (HREADY) begin
                    d_fin = 1'b1;
                    d_err = 1'b1;
                end
            end
            default: ;
        endcase

        if (state_q == S_ERR2)
            can_issue = HREADY;
        else
            can_issue = !enter_err & (!a_v_q | a_adv);

        if (d_fin) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = d_err;
            rsp_rdata_d = (d_err | d_wr_q) ? 32'h0 : HRDATA;
            hwdata_d    = 32'h0;
        end

        if (a_adv) begin
            a_v_d    = 1'b0;
            d_wr_d   = hwrite_q;
            hwdata_d = hwrite_q ? a_wdata_q : 32'h0;
        end

        // Cancel an overlapped address phase; it is reissued once ERR2 ends.
        if (enter_err & a_v_q) begin
            a_v_d    = 1'b0;
            a_hold_d = 1'b1;
        end

        if (can_issue) begin
            if (a_hold_q) begin
                a_v_d    = 1'b1;
                a_hold_d = 1'b0;
            end else if (p_v_q) begin
                a_v_d     = 1'b1;
                p_v_d     = 1'b0;
                haddr_d   = p_addr_q;
                hwrite_d  = p_write_q;
                hsize_d   = p_size_q;
                a_wdata_d = p_wdata_q;
            end else if (acc) begin
                a_v_d     = 1'b1;
                took      = 1'b1;
                haddr_d   = c_addr;
                hwrite_d  = cmd_write;
                hsize_d   = c_size;
                a_wdata_d = cmd_wdata;
            end
        end

        if (acc & !took) begin
            p_v_d     = 1'b1;
            p_addr_d  = c_addr;
            p_write_d = cmd_write;
            p_size_d  = c_size;
            p_wdata_d = cmd_wdata;
        end

        if (enter_err)
            state_d = S_ERR2;
        else if ((state_q == S_ERR2) & !HREADY)
            state_d = S_ERR2;
        else if (a_adv)
            state_d = S_DATA;
        else if ((state_q == S_DATA) & !HREADY)
            state_d = S_DATA;
        else if (a_v_d)
            state_d = S_ADDR;
        else
            state_d = S_IDLE;

        cmd_ready_d = PIPE ? !p_v_d : (state_d == S_IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            a_v_q       <= 1'b0;
            a_hold_q    <= 1'b0;
            haddr_q     <= 32'h0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 2'd0;
            a_wdata_q   <= 32'h0;
            d_wr_q      <= 1'b0;
            hwdata_q    <= 32'h0;
            p_v_q       <= 1'b0;
            p_addr_q    <= 32'h0;
            p_write_q   <= 1'b0;
            p_size_q    <= 2'd0;
            p_wdata_q   <= 32'h0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            a_v_q       <= a_v_d;
            a_hold_q    <= a_hold_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            a_wdata_q   <= a_wdata_d;
            d_wr_q      <= d_wr_d;
            hwdata_q    <= hwdata_d;
            p_v_q       <= p_v_d;
            p_addr_q    <= p_addr_d;
            p_write_q   <= p_write_d;
            p_size_q    <= p_size_d;
            p_wdata_q   <= p_wdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = {1'b0, hsize_q};
    assign HTRANS    = a_v_q ? 2'b10 : 2'b00;
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VAL;

endmodule
